// File: rtl/secret_result_buffer.sv
// Capture buffer for the accumulator result: a first-word-fall-through FIFO with a
// valid/ready output, a saturating drop counter and a wrapping checksum of delivered words.
module secret_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           x_in,
    input  logic                       capture_en,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_count,
    output logic [WIDTH-1:0]           sum
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_nxt;
    logic [AW:0]      rd_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Occupancy comes straight from the extra pointer bit, so full and empty never alias.
    assign level     = wr_ptr - rd_ptr;
    assign out_valid = (wr_ptr != rd_ptr);
    assign full      = (level == (AW+1)'(DEPTH));
    assign pop       = out_valid & out_ready & ~flush;
    assign push      = capture_en & ~flush & (~full | pop);
    assign drop      = capture_en & ~flush & ~push;

    always_comb begin
        rd_nxt   = rd_ptr;
        wr_nxt   = wr_ptr;
        head_nxt = out_data;
        if (flush) begin
            rd_nxt = wr_ptr;
        end else begin
            if (pop)  rd_nxt = rd_ptr + (AW+1)'(1);
            if (push) wr_nxt = wr_ptr + (AW+1)'(1);
        end
        // Register the next head; a word written this edge into the head slot comes from x_in.
        if (wr_nxt != rd_nxt) begin
            if (push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
                head_nxt = x_in;
            else
                head_nxt = mem[rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= x_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_data   <= '0;
            drop_count <= '0;
            sum        <= '0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            out_data <= head_nxt;
            if (drop) drop_count <= sat_inc(drop_count);
            if (pop)  sum        <= sum + out_data;
        end
    end

endmodule

// File: tb/tb_secret_result_buffer.sv
// Self-checking bench for secret_result_buffer: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_secret_result_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] x_in = '0;
    logic        capture_en = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [3:0]  level;
    logic [15:0] drop_count;
    logic [31:0] sum;

    secret_result_buffer #(.WIDTH(32), .DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .capture_en(capture_en), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .drop_count(drop_count), .sum(sum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: contents as a queue, plus counters.
    logic [31:0] q[$];
    logic [15:0] m_drop;
    logic [31:0] m_sum;
    logic [31:0] m_last;

    typedef struct {
        logic        cap;
        logic [31:0] x;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  el;
        logic [15:0] edr;
        logic [31:0] es;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drop = '0;
        m_sum  = '0;
        m_last = '0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, ".level"}, 64'(level), 64'(q.size()));
        chk({tag, ".drop"}, 64'(drop_count), 64'(m_drop));
        chk({tag, ".sum"}, 64'(sum), 64'(m_sum));
        chk({tag, ".data"}, 64'(out_data), 64'(m_last));
    endtask

    task automatic cyc(input logic cap, input logic [31:0] x, input logic fl, input logic rdy,
                       input string tag);
        bit pop, push;
        capture_en = cap;
        x_in       = x;
        flush      = fl;
        out_ready  = rdy;
        pop  = (q.size() != 0) && rdy && !fl;
        push = cap && !fl && ((q.size() < 8) || pop);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) begin
                m_sum = m_sum + q[0];
                void'(q.pop_front());
            end
            if (push) q.push_back(x);
            else if (cap && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        if (q.size() != 0) m_last = q[0];
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        capture_en = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input int cap, input int x, input int rdy, input int ev,
                           input int ed, input int el, input int edr, input int es);
        tbl[i].cap = 1'(cap);
        tbl[i].x   = 32'(x);
        tbl[i].fl  = 1'b0;
        tbl[i].rdy = 1'(rdy);
        tbl[i].ev  = 1'(ev);
        tbl[i].ed  = 32'(ed);
        tbl[i].el  = 4'(el);
        tbl[i].edr = 16'(edr);
        tbl[i].es  = 32'(es);
    endtask

    logic [15:0] d_saved;

    initial begin
        // Fill and overflow: 10 captures with the output stalled, then a full drain.
        for (int k = 1; k <= 10; k++)
            set_vec(k - 1, 1, k, 0, 1, 1, (k <= 8) ? k : 8, (k <= 8) ? 0 : k - 8, 0);
        for (int i = 1; i <= 8; i++)
            set_vec(9 + i, 0, 0, 1, (i < 8) ? 1 : 0, (i < 8) ? i + 1 : 8, 8 - i, 2, i * (i + 1) / 2);

        do_reset();
        chk("reset.valid", 64'(out_valid), 64'd0);
        chk("reset.level", 64'(level), 64'd0);
        chk("reset.drop", 64'(drop_count), 64'd0);
        chk("reset.sum", 64'(sum), 64'd0);
        chk("reset.data", 64'(out_data), 64'd0);

        // Basic latency: no same-cycle bypass, one cycle of valid.
        capture_en = 1'b1; x_in = 32'h5; out_ready = 1'b1;
        #1;
        chk("lat.nobypass", 64'(out_valid), 64'd0);
        cyc(1'b1, 32'h5, 1'b0, 1'b1, "lat.cap");
        chk("lat.data", 64'(out_data), 64'h5);
        chk("lat.valid", 64'(out_valid), 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, "lat.pop");
        chk("lat.sum", 64'(sum), 64'h5);
        chk("lat.level", 64'(level), 64'd0);
        chk("lat.empty", 64'(out_valid), 64'd0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].cap, tbl[i].x, tbl[i].fl, tbl[i].rdy, "tbl");
            chk($sformatf("tbl%0d.valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.data", i), 64'(out_data), 64'(tbl[i].ed));
            chk($sformatf("tbl%0d.level", i), 64'(level), 64'(tbl[i].el));
            chk($sformatf("tbl%0d.drop", i), 64'(drop_count), 64'(tbl[i].edr));
            chk($sformatf("tbl%0d.sum", i), 64'(sum), 64'(tbl[i].es));
        end

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int k = 1; k <= 8; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0, "fpp.fill");
        cyc(1'b1, 32'h9, 1'b0, 1'b1, "fpp.both");
        chk("fpp.level", 64'(level), 64'd8);
        chk("fpp.drop", 64'(drop_count), 64'd0);
        chk("fpp.head", 64'(out_data), 64'h2);
        chk("fpp.sum", 64'(sum), 64'h1);
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("fpp.order%0d", k), 64'(out_data), 64'(k));
            cyc(1'b0, 32'h0, 1'b0, 1'b1, "fpp.drain");
        end
        chk("fpp.emptied", 64'(out_valid), 64'd0);
        chk("fpp.last", 64'(out_data), 64'h9);

        // Flush beats a same-cycle push and pop.
        do_reset();
        for (int k = 1; k <= 3; k++) cyc(1'b1, 32'(k + 16), 1'b0, 1'b0, "fl.fill");
        cyc(1'b1, 32'hAA, 1'b1, 1'b1, "fl.flush");
        chk("fl.level", 64'(level), 64'd0);
        chk("fl.valid", 64'(out_valid), 64'd0);
        chk("fl.sum", 64'(sum), 64'd0);
        chk("fl.drop", 64'(drop_count), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, "fl.after");
        chk("fl.noAA", 64'(out_valid), 64'd0);

        // Checksum wraps modulo 2^32.
        do_reset();
        cyc(1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, "wrap.c0");
        cyc(1'b1, 32'h20, 1'b0, 1'b1, "wrap.c1");
        cyc(1'b0, 32'h0, 1'b0, 1'b1, "wrap.p");
        chk("wrap.sum", 64'(sum), 64'h10);

        // Asynchronous reset between edges with 5 queued and 3 drops.
        do_reset();
        for (int k = 1; k <= 11; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0, "ar.fill");
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b0, 1'b1, "ar.pop");
        chk("ar.pre.level", 64'(level), 64'd5);
        chk("ar.pre.drop", 64'(drop_count), 64'd3);
        capture_en = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar.valid", 64'(out_valid), 64'd0);
        chk("ar.level", 64'(level), 64'd0);
        chk("ar.drop", 64'(drop_count), 64'd0);
        chk("ar.sum", 64'(sum), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 32'h7, 1'b0, 1'b0, "ar.cap");
        chk("ar.first", 64'(out_data), 64'h7);
        chk("ar.first.level", 64'(level), 64'd1);

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 30 : 80)), "rnd");
        end
        d_saved = drop_count;
        chk("rnd.drops_seen", 64'(d_saved != 0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
